stopwatch_bcd_counter: RTL and testbench

Stopwatch core that consumes the divided 100 Hz square wave and keeps elapsed time as six BCD digits (MM:SS.cc). It runs in the 50 MHz `CLOCK` domain and treats the 100 Hz signal as data: it synchronises the signal and uses its rising edges as count enables. Two key inputs drive a start/stop/lap/clear state machine. The registered BCD outputs feed the seven-segment display mux.

---
 rtl/stopwatch_bcd_counter.sv | 175 +++++++++++++++++
 tb/tb_stopwatch_bcd_counter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch core: MM:SS.cc BCD count with start/stop/lap/clear control.
// The 100 Hz input and both keys are sampled as data in the CLOCK domain.
module stopwatch_bcd_counter #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       clk_100Hz_in,
  input  logic       key_start_stop,
  input  logic       key_lap_clear,
  output logic [3:0] cs_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       lap_hold,
  output logic       wrap
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_LAP   = 2'd2;
  localparam logic [1:0] S_PAUSE = 2'd3;

  // Input lanes: [0] 100 Hz, [1] start/stop key, [2] lap/clear key.
  logic [2:0]                  w_raw;
  logic [2:0]                  w_synced;
  logic [2:0][SYNC_STAGES-1:0] r_sync;
  logic [2:0]                  r_edge;
  logic [2:0]                  r_pulse;

  logic w_tick;
  logic w_press_ss;
  logic w_press_lc;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [5:0][3:0] r_live;
  logic [5:0][3:0] r_snap;
  logic [5:0][3:0] r_disp;
  logic [5:0][3:0] w_inc;
  logic [5:0][3:0] w_live_nxt;
  logic [5:0][3:0] w_snap_nxt;
  logic [5:0][3:0] w_disp_nxt;
  logic            w_rollover;
  logic            w_count_en;
  logic            r_running;
  logic            r_lap_hold;
  logic            r_wrap;

  assign w_raw = {key_lap_clear, key_start_stop, clk_100Hz_in};

  always_comb begin
    w_synced = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      w_synced[i] = r_sync[i][SYNC_STAGES-1];
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_sync  <= '0;
      r_edge  <= '0;
      r_pulse <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_raw[i]};
      end
      r_edge  <= w_synced;
      r_pulse <= w_synced & ~r_edge;
    end
  end

  assign w_tick     = r_pulse[0];
  assign w_press_ss = r_pulse[1];
  assign w_press_lc = r_pulse[2];

  function automatic logic [3:0] digit_max(input int unsigned idx);
    return (idx == 3 || idx == 5) ? 4'd5 : 4'd9;
  endfunction

  // Ripple increment; '>=' folds any out-of-range digit back to zero.
  always_comb begin
    logic carry;
    w_inc = r_live;
    carry = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      if (carry) begin
        if (r_live[3'(i)] >= digit_max(i)) begin
          w_inc[3'(i)] = '0;
        end else begin
          w_inc[3'(i)] = r_live[3'(i)] + 4'd1;
          carry        = 1'b0;
        end
      end
    end
    w_rollover = carry;
  end

  // Count enable uses the pre-transition state; snapshot takes the pre-increment value.
  always_comb begin
    w_state_nxt = r_state;
    w_snap_nxt  = r_snap;
    w_count_en  = w_tick && (r_state == S_RUN || r_state == S_LAP);
    w_live_nxt  = w_count_en ? w_inc : r_live;
    case (r_state)
      S_IDLE: begin
        if (w_press_ss) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_press_ss) begin
          w_state_nxt = S_PAUSE;
        end else if (w_press_lc) begin
          w_state_nxt = S_LAP;
          w_snap_nxt  = r_live;
        end
      end
      S_LAP: begin
        if (w_press_ss) begin
          w_state_nxt = S_PAUSE;
        end else if (w_press_lc) begin
          w_state_nxt = S_RUN;
        end
      end
      S_PAUSE: begin
        if (w_press_ss) begin
          w_state_nxt = S_RUN;
        end else if (w_press_lc) begin
          w_state_nxt = S_IDLE;
          w_live_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_live_nxt  = '0;
      end
    endcase
    w_disp_nxt = (w_state_nxt == S_LAP) ? w_snap_nxt : w_live_nxt;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_live     <= '0;
      r_snap     <= '0;
      r_disp     <= '0;
      r_running  <= 1'b0;
      r_lap_hold <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_live     <= w_live_nxt;
      r_snap     <= w_snap_nxt;
      r_disp     <= w_disp_nxt;
      r_running  <= (r_state == S_RUN) || (r_state == S_LAP);
      r_lap_hold <= (r_state == S_LAP);
      r_wrap     <= w_count_en && w_rollover;
    end
  end

  assign cs_ones  = r_disp[0];
  assign cs_tens  = r_disp[1];
  assign sec_ones = r_disp[2];
  assign sec_tens = r_disp[3];
  assign min_ones = r_disp[4];
  assign min_tens = r_disp[5];
  assign running  = r_running;
  assign lap_hold = r_lap_hold;
  assign wrap     = r_wrap;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench for stopwatch_bcd_counter: run/pause, lap, clear, wrap, reset.
module tb_stopwatch_bcd_counter;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       clk_100Hz_in = 1'b0;
  logic       key_start_stop = 1'b0;
  logic       key_lap_clear = 1'b0;
  logic [3:0] cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens;
  logic       running, lap_hold, wrap;

  int errors = 0;
  int checks = 0;
  int wrap_cycles = 0;
  int wrap_nonzero = 0;

  always #10 CLOCK = ~CLOCK;

  stopwatch_bcd_counter #(.SYNC_STAGES(2)) dut (
    .CLOCK          (CLOCK),
    .RESET          (RESET),
    .clk_100Hz_in   (clk_100Hz_in),
    .key_start_stop (key_start_stop),
    .key_lap_clear  (key_lap_clear),
    .cs_ones        (cs_ones),
    .cs_tens        (cs_tens),
    .sec_ones       (sec_ones),
    .sec_tens       (sec_tens),
    .min_ones       (min_ones),
    .min_tens       (min_tens),
    .running        (running),
    .lap_hold       (lap_hold),
    .wrap           (wrap)
  );

  function automatic logic [23:0] disp();
    return {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones};
  endfunction

  always @(negedge CLOCK) begin
    if (wrap === 1'b1) begin
      wrap_cycles++;
      if (disp() !== 24'h000000) wrap_nonzero++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      clk_100Hz_in = 1'b1;
      repeat (3) @(negedge CLOCK);
      clk_100Hz_in = 1'b0;
      repeat (3) @(negedge CLOCK);
    end
  endtask

  task automatic press(input logic ss, input logic lc);
    key_start_stop = ss;
    key_lap_clear  = lc;
    repeat (3) @(negedge CLOCK);
    key_start_stop = 1'b0;
    key_lap_clear  = 1'b0;
    repeat (3) @(negedge CLOCK);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge CLOCK);
    checks++;
    if (disp() !== 24'h000000) begin
      errors++; $display("FAIL reset_digits got %h exp 000000", disp());
    end
    checks++;
    if ({running, lap_hold, wrap} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b exp 000", {running, lap_hold, wrap});
    end
    RESET = 1'b0;
    repeat (2) @(negedge CLOCK);
  endtask

  task automatic test_idle_ticks();
    tick(10);
    checks++;
    if (disp() !== 24'h000000) begin
      errors++; $display("FAIL idle_ticks got %h exp 000000", disp());
    end
    checks++;
    if (running !== 1'b0) begin
      errors++; $display("FAIL idle_running got %b exp 0", running);
    end
  endtask

  task automatic test_run_pause();
    press(1'b1, 1'b0);
    checks++;
    if ({running, lap_hold} !== 2'b10) begin
      errors++; $display("FAIL start_flags got %b exp 10", {running, lap_hold});
    end
    tick(100);
    checks++;
    if (disp() !== 24'h000100) begin
      errors++; $display("FAIL run_100 got %h exp 000100", disp());
    end
    press(1'b1, 1'b0);
    checks++;
    if (running !== 1'b0) begin
      errors++; $display("FAIL pause_running got %b exp 0", running);
    end
    tick(50);
    checks++;
    if (disp() !== 24'h000100) begin
      errors++; $display("FAIL pause_hold got %h exp 000100", disp());
    end
  endtask

  task automatic test_pause_clear();
    press(1'b1, 1'b0);
    tick(207);
    press(1'b1, 1'b0);
    checks++;
    if (disp() !== 24'h000307) begin
      errors++; $display("FAIL pause_307 got %h exp 000307", disp());
    end
    press(1'b0, 1'b1);
    checks++;
    if (disp() !== 24'h000000) begin
      errors++; $display("FAIL clear_digits got %h exp 000000", disp());
    end
    checks++;
    if (running !== 1'b0) begin
      errors++; $display("FAIL clear_running got %b exp 0", running);
    end
    tick(3);
    checks++;
    if (disp() !== 24'h000000) begin
      errors++; $display("FAIL cleared_idle_ticks got %h exp 000000", disp());
    end
    press(1'b1, 1'b1);
    checks++;
    if ({running, lap_hold} !== 2'b10) begin
      errors++; $display("FAIL both_keys_flags got %b exp 10", {running, lap_hold});
    end
    checks++;
    if (disp() !== 24'h000000) begin
      errors++; $display("FAIL both_keys_digits got %h exp 000000", disp());
    end
  endtask

  task automatic test_lap();
    tick(25);
    checks++;
    if (disp() !== 24'h000025) begin
      errors++; $display("FAIL run_25 got %h exp 000025", disp());
    end
    press(1'b0, 1'b1);
    checks++;
    if ({running, lap_hold} !== 2'b11) begin
      errors++; $display("FAIL lap_flags got %b exp 11", {running, lap_hold});
    end
    tick(30);
    checks++;
    if (disp() !== 24'h000025) begin
      errors++; $display("FAIL lap_frozen got %h exp 000025", disp());
    end
    press(1'b0, 1'b1);
    checks++;
    if (disp() !== 24'h000055) begin
      errors++; $display("FAIL lap_release got %h exp 000055", disp());
    end
    checks++;
    if (lap_hold !== 1'b0) begin
      errors++; $display("FAIL lap_release_hold got %b exp 0", lap_hold);
    end
    press(1'b0, 1'b1);
    tick(5);
    checks++;
    if (disp() !== 24'h000055) begin
      errors++; $display("FAIL lap2_frozen got %h exp 000055", disp());
    end
    press(1'b1, 1'b0);
    checks++;
    if (disp() !== 24'h000060) begin
      errors++; $display("FAIL lap_to_pause got %h exp 000060", disp());
    end
    checks++;
    if ({running, lap_hold} !== 2'b00) begin
      errors++; $display("FAIL lap_to_pause_flags got %b exp 00", {running, lap_hold});
    end
    press(1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    @(negedge CLOCK);
    force dut.r_live = 24'h595999;
    @(negedge CLOCK);
    release dut.r_live;
    @(negedge CLOCK);
    checks++;
    if (disp() !== 24'h595999) begin
      errors++; $display("FAIL preload got %h exp 595999", disp());
    end
    wrap_cycles  = 0;
    wrap_nonzero = 0;
    tick(1);
    checks++;
    if (disp() !== 24'h000000) begin
      errors++; $display("FAIL wrap_digits got %h exp 000000", disp());
    end
    checks++;
    if (wrap_cycles !== 1) begin
      errors++; $display("FAIL wrap_pulse_len got %0d exp 1", wrap_cycles);
    end
    checks++;
    if (wrap_nonzero !== 0) begin
      errors++; $display("FAIL wrap_alignment got %0d exp 0", wrap_nonzero);
    end
    tick(1);
    checks++;
    if (disp() !== 24'h000001) begin
      errors++; $display("FAIL after_wrap got %h exp 000001", disp());
    end
  endtask

  task automatic test_reset_mid_run();
    tick(1233);
    checks++;
    if (disp() !== 24'h001234) begin
      errors++; $display("FAIL run_1234 got %h exp 001234", disp());
    end
    RESET = 1'b1;
    #1;
    checks++;
    if (disp() !== 24'h000000 || running !== 1'b0) begin
      errors++; $display("FAIL async_reset got %h/%b exp 000000/0", disp(), running);
    end
    repeat (2) @(negedge CLOCK);
    RESET = 1'b0;
    repeat (2) @(negedge CLOCK);
    tick(1);
    checks++;
    if (disp() !== 24'h000000) begin
      errors++; $display("FAIL post_reset_tick got %h exp 000000", disp());
    end
    checks++;
    if ({running, lap_hold, wrap} !== 3'b000) begin
      errors++; $display("FAIL post_reset_flags got %b exp 000", {running, lap_hold, wrap});
    end
  endtask

  initial begin
    test_reset();
    test_idle_ticks();
    test_run_pause();
    test_pause_clear();
    test_lap();
    test_wrap();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
